// File: rtl/core_defines_pkg.sv
// Shared core-wide constants and types for the fetch path.
package core_defines;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [XLEN-1:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  typedef enum logic [1:0] {
    ACK_NONE,
    ACK_STALE,
    ACK_LIVE,
    ACK_SPURIOUS
  } ack_kind_e;

  // Stale drops take precedence over live completions: acks return in order.
  function automatic ack_kind_e classify_ack(input logic ack, input logic stale_pending,
                                             input logic live_pending);
    if (!ack)               return ACK_NONE;
    else if (stale_pending) return ACK_STALE;
    else if (live_pending)  return ACK_LIVE;
    else                    return ACK_SPURIOUS;
  endfunction

endpackage

// File: rtl/core_sync_fifo.sv
// Synchronous FIFO with counter-based full/empty and a synchronous clear.
module core_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  // Head reads as zero when empty so downstream sees clean outputs.
  assign dout   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/core_fetch_queue.sv
// Fetch queue: pairs in-order L1I acks with request PCs and buffers {pc, instr} for decode.
module core_fetch_queue
  import core_defines::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fq_req_val,
  input  logic [XLEN-1:0] fq_req_addr,
  output logic            fq_req_rdy,
  input  logic            fq_flush,
  output logic            l1i_req_val,
  output logic [XLEN-1:0] l1i_req_addr,
  input  logic            l1i_ack,
  input  logic [XLEN-1:0] l1i_ack_rdata,
  output logic            fq_inst_val,
  output logic [XLEN-1:0] fq_inst,
  output logic [XLEN-1:0] fq_inst_pc,
  input  logic            fq_inst_rdy,
  output logic            fq_err
);

  localparam int unsigned SUM_W = CNT_W + 2;

  logic [CNT_W-1:0] out_cnt, q_cnt, stale_cnt;
  logic [SUM_W-1:0] credit_sum;
  logic             req_fire, ack_used;
  logic             pc_full, pc_empty, dq_full, dq_empty;
  logic [XLEN-1:0]  pc_head;
  fq_entry_t        push_entry, head_entry;
  ack_kind_e        ack_kind;

  assign credit_sum = {2'b00, out_cnt} + {2'b00, q_cnt} + {2'b00, stale_cnt};
  assign fq_req_rdy = !rst && !fq_flush && (credit_sum < SUM_W'(DEPTH));
  assign req_fire   = fq_req_val && fq_req_rdy;

  assign l1i_req_val  = req_fire;
  assign l1i_req_addr = req_fire ? fq_req_addr : '0;

  assign ack_kind = classify_ack(l1i_ack, stale_cnt != '0, !pc_empty);
  assign ack_used = (ack_kind == ACK_STALE) || (ack_kind == ACK_LIVE);

  assign push_entry = '{pc: pc_head, instr: l1i_ack_rdata};

  core_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fq_flush),
    .push  (req_fire),
    .din   (fq_req_addr),
    .pop   (ack_kind == ACK_LIVE && !fq_flush),
    .dout  (pc_head),
    .full  (pc_full),
    .empty (pc_empty),
    .count (out_cnt)
  );

  core_sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fq_flush),
    .push  (ack_kind == ACK_LIVE && !fq_flush),
    .din   (push_entry),
    .pop   (fq_inst_val && fq_inst_rdy && !fq_flush),
    .dout  (head_entry),
    .full  (dq_full),
    .empty (dq_empty),
    .count (q_cnt)
  );

  assign fq_inst_val = !dq_empty;
  assign fq_inst     = head_entry.instr;
  assign fq_inst_pc  = head_entry.pc;

  // On flush every live request becomes stale; an ack landing in the same cycle retires one of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_cnt <= '0;
      fq_err    <= 1'b0;
    end else begin
      if (ack_kind == ACK_SPURIOUS) fq_err <= 1'b1;
      if (fq_flush)
        stale_cnt <= stale_cnt + out_cnt - {{(CNT_W-1){1'b0}}, ack_used};
      else if (ack_kind == ACK_STALE)
        stale_cnt <= stale_cnt - CNT_W'(1);
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (rst) credit_sum <= SUM_W'(DEPTH));
  a_pc_room: assert property (@(posedge clk) disable iff (rst) !(req_fire && pc_full));
  a_dq_room: assert property (@(posedge clk) disable iff (rst)
                              !(ack_kind == ACK_LIVE && !fq_flush && dq_full && !(fq_inst_val && fq_inst_rdy)));

endmodule

// File: tb/tb_core_fetch_queue.sv
// Bench for core_fetch_queue: vector table plus hand sequences, with a {pc, instr} scoreboard.
module tb_core_fetch_queue;
  import core_defines::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fq_req_val = 1'b0;
  logic [31:0] fq_req_addr = '0;
  logic        fq_req_rdy;
  logic        fq_flush = 1'b0;
  logic        l1i_req_val;
  logic [31:0] l1i_req_addr;
  logic        l1i_ack = 1'b0;
  logic [31:0] l1i_ack_rdata = '0;
  logic        fq_inst_val;
  logic [31:0] fq_inst;
  logic [31:0] fq_inst_pc;
  logic        fq_inst_rdy = 1'b0;
  logic        fq_err;

  core_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .fq_req_val    (fq_req_val),
    .fq_req_addr   (fq_req_addr),
    .fq_req_rdy    (fq_req_rdy),
    .fq_flush      (fq_flush),
    .l1i_req_val   (l1i_req_val),
    .l1i_req_addr  (l1i_req_addr),
    .l1i_ack       (l1i_ack),
    .l1i_ack_rdata (l1i_ack_rdata),
    .fq_inst_val   (fq_inst_val),
    .fq_inst       (fq_inst),
    .fq_inst_pc    (fq_inst_pc),
    .fq_inst_rdy   (fq_inst_rdy),
    .fq_err        (fq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] pend[$];
  fq_entry_t   exp_q[$];

  typedef struct {
    logic        rv;
    logic [31:0] a;
    logic        fl, ak, ir;
    logic        e_rdy, e_l1i, e_val;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[17];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; the L1I model answers acks from its in-order pending list.
  task automatic drive(input logic rv, input logic [31:0] a, input logic fl,
                       input logic ak, input logic ir);
    @(posedge clk);
    #1;
    fq_req_val    = rv;
    fq_req_addr   = a;
    fq_flush      = fl;
    l1i_ack       = ak;
    fq_inst_rdy   = ir;
    l1i_ack_rdata = NOP;
    if (ak && pend.size() != 0) l1i_ack_rdata = instr_of(pend.pop_front());
    #1;
  endtask

  always @(negedge clk) begin
    fq_entry_t e;
    if (rst) begin
      pend.delete();
      exp_q.delete();
    end else begin
      if (fq_inst_val && fq_inst_rdy && !fq_flush) begin
        if (exp_q.size() == 0) chk("sb_unexpected_val", 32'(fq_inst_val), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_pc", fq_inst_pc, e.pc);
          chk("sb_instr", fq_inst, e.instr);
        end
      end
      if (fq_flush) exp_q.delete();
      if (l1i_req_val) begin
        chk("l1i_addr", l1i_req_addr, fq_req_addr);
        pend.push_back(fq_req_addr);
        e.pc    = fq_req_addr;
        e.instr = instr_of(fq_req_addr);
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // streaming, ack latency 1, decode always ready
    vecs[0]  = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h4,    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h8,    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
    vecs[4]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8};
    vecs[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    // backpressure: decode stalled until the queue fills
    vecs[6]  = '{1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h1004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h1008, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000};
    vecs[9]  = '{1'b1, 32'h100C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000};
    vecs[10] = '{1'b1, 32'h1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000};
    vecs[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1004};
    vecs[13] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1004};
    vecs[14] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1008};
    vecs[15] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100C};
    vecs[16] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    #1 rst = 1'b1;
    #1;
    chk("rst_req_rdy",  32'(fq_req_rdy),  32'd0);
    chk("rst_l1i_val",  32'(l1i_req_val), 32'd0);
    chk("rst_l1i_addr", l1i_req_addr,     32'd0);
    chk("rst_inst_val", 32'(fq_inst_val), 32'd0);
    chk("rst_inst",     fq_inst,          32'd0);
    chk("rst_inst_pc",  fq_inst_pc,       32'd0);
    chk("rst_err",      32'(fq_err),      32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_req_rdy", 32'(fq_req_rdy), 32'd1);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rv, vecs[i].a, vecs[i].fl, vecs[i].ak, vecs[i].ir);
      chk($sformatf("v%0d_req_rdy", i),  32'(fq_req_rdy),  32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_l1i_val", i),  32'(l1i_req_val), 32'(vecs[i].e_l1i));
      chk($sformatf("v%0d_inst_val", i), 32'(fq_inst_val), 32'(vecs[i].e_val));
      chk($sformatf("v%0d_inst_pc", i),  fq_inst_pc,       vecs[i].e_pc);
    end

    // flush with two requests in flight, redirect to 0x100
    drive(1'b1, 32'h10,  1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h14,  1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("flush_req_rdy", 32'(fq_req_rdy),  32'd0);
    chk("flush_l1i_val", 32'(l1i_req_val), 32'd0);
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    chk("flush_stale2",   32'(dut.stale_cnt), 32'd2);
    chk("redir_req_rdy",  32'(fq_req_rdy),    32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("flush_stale1",   32'(dut.stale_cnt), 32'd1);
    chk("flush_drop_val", 32'(fq_inst_val),   32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("flush_stale0",   32'(dut.stale_cnt), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("redir_val", 32'(fq_inst_val), 32'd1);
    chk("redir_pc",  fq_inst_pc,       32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("redir_empty", 32'(fq_inst_val), 32'd0);

    // flush coinciding with an ack
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h28, 1'b1, 1'b1, 1'b1);
    chk("flack_req_rdy", 32'(fq_req_rdy), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("flack_stale1", 32'(dut.stale_cnt), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flack_stale0", 32'(dut.stale_cnt), 32'd0);
    chk("flack_val",    32'(fq_inst_val),   32'd0);

    // spurious ack
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("spur_err_before", 32'(fq_err), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("spur_err", 32'(fq_err),      32'd1);
    chk("spur_val", 32'(fq_inst_val), 32'd0);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("spur_err_sticky", 32'(fq_err),      32'd1);
    chk("spur_val_later",  32'(fq_inst_val), 32'd0);

    // asynchronous reset between edges with data queued
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0,  1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
    chk("pre_rst_val", 32'(fq_inst_val), 32'd1);
    chk("pre_rst_pc",  fq_inst_pc,       32'h40);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_val",     32'(fq_inst_val), 32'd0);
    chk("mid_rst_inst",    fq_inst,          32'd0);
    chk("mid_rst_pc",      fq_inst_pc,       32'd0);
    chk("mid_rst_err",     32'(fq_err),      32'd0);
    chk("mid_rst_req_rdy", 32'(fq_req_rdy),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    chk("after_rst_l1i", 32'(l1i_req_val), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("after_rst_stale", 32'(dut.stale_cnt), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("after_rst_val",  32'(fq_inst_val), 32'd1);
    chk("after_rst_pc",   fq_inst_pc,       32'h200);
    chk("after_rst_inst", fq_inst,          instr_of(32'h200));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("final_val", 32'(fq_inst_val), 32'd0);
    chk("sb_drain",  32'(exp_q.size()), 32'd0);
    chk("l1i_drain", 32'(pend.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
